fb_mem_arbiter: RTL and testbench
=================================

// Module: fb_mem_arbiter
// PURPOSE
// Shares one single-port framebuffer memory between the scanout pixel fetcher (read-only) and a host
// writer (write-only). Uses fb_hblank/fb_vblank from vga_renderer to schedule priority: display wins
// during active video and late vblank, host wins in early vblank, with a starvation guard for the host.
// Sits between the fetcher/host ports and the memory controller command interface.
// PARAMETERS
// ADDR_BITS          19  memory word address width (800x480 = 384000 words)
// DATA_BITS          24  write data width (8:8:8 RGB)
// HOST_MAX_WAIT      16  cycles a blocked host waits before forcing one grant during display priority
// VBLANK_HOST_LINES  20  vblank lines (fb_hblank rising edges) of host priority before PREFETCH
// PORTS
// vga_clk     in   1          pixel clock; all logic on rising edge
// reset       in   1          asynchronous, active-high reset
// fb_hblank   in   1          from vga_renderer
// fb_vblank   in   1          from vga_renderer
// disp_req    in   1          fetcher read request; hold with disp_addr stable until disp_gnt
// disp_addr   in   ADDR_BITS  read address
// disp_urgent in   1          fetcher FIFO below low watermark; overrides all host priority
// disp_gnt    out  1          combinational; read accepted at edge where disp_req && disp_gnt
// host_req    in   1          host write request; hold fields stable until host_gnt
// host_addr   in   ADDR_BITS  write address
// host_wdata  in   DATA_BITS  write data
// host_gnt    out  1          combinational; write accepted at edge where host_req && host_gnt
// mem_valid   out  1          registered command valid to memory
// mem_we      out  1          registered: 1 = write (host), 0 = read (display)
// mem_addr    out  ADDR_BITS  registered command address
// mem_wdata   out  DATA_BITS  registered write data (don't-care on reads; holds last value)
// mem_ready   in   1          memory accepts command at edge where mem_valid && mem_ready
// arb_state   out  2          debug: 0 ACTIVE, 1 VBLANK, 2 PREFETCH
// host_starved out 1          registered; high while host wait counter == HOST_MAX_WAIT
// BEHAVIOUR
// - Reset: state ACTIVE, mem_valid/mem_we/host_starved=0, mem_addr/mem_wdata=0, wait/line counters 0,
//   vblank_q/hblank_q=0. Grants are 0 while reset high. Pending command is dropped; requesters retry.
// - slot_free = !mem_valid || mem_ready. Grant only when slot_free; at most one grant per cycle.
// - Selection when both request: ACTIVE/PREFETCH -> display, unless host_wait==HOST_MAX_WAIT and
//   !disp_urgent, then host. VBLANK -> host, unless disp_urgent. Single requester always wins.
// - On accepted grant, next edge loads mem_valid=1 and fields; zero-cycle bubble between back-to-back
//   commands when mem_ready stays high. If slot_free and no accept, mem_valid <= 0.
// - mem_valid && !mem_ready: all mem_* held stable, both grants 0.
// - host_wait: +1 per cycle host_req && !host_gnt (saturate at HOST_MAX_WAIT); cleared on host_gnt
//   accept or host_req low. Forced host grant clears it, so display regains priority next slot.
// - FSM (edges from registered vblank_q/hblank_q):
//   ACTIVE -> VBLANK on fb_vblank rise (line_cnt <= 0).
//   VBLANK: line_cnt +1 on each fb_hblank rise; -> PREFETCH when line_cnt == VBLANK_HOST_LINES
//     (VBLANK_HOST_LINES=0 -> PREFETCH after one cycle); -> ACTIVE directly on fb_vblank fall.
//   PREFETCH -> ACTIVE on fb_vblank fall.
//   hblank rise in same cycle as vblank rise is not counted. line_cnt saturates, never wraps.
// - Latency: request to mem_valid = 1 cycle when slot free; selection uses current-cycle state.
// TESTING
// - Reset mid-command (mem_valid=1, mem_ready=0) -> mem_valid=0 asynchronously, grants 0, state ACTIVE.
// - ACTIVE, disp_req and host_req held, mem_ready=1 -> 16 display grants, then 1 host grant, repeat;
//   host_starved high exactly on the forced-grant cycle.
// - Same as above with disp_urgent=1 -> host never granted; host_wait stays 16.
// - Renderer timing 800x480: vblank rise -> VBLANK; host wins ties for 20 line edges -> PREFETCH;
//   vblank fall (26 lines) -> ACTIVE; arb_state sequence 0,1,2,0.
// - mem_ready low 5 cycles with host write pending -> mem_addr/mem_wdata stable, no grants;
//   ready high -> accept, next grant same cycle, no bubble.
// - Single requester at each state, host only in ACTIVE -> host granted every cycle (no starvation wait).

Source files
------------

// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its two requesters and the
// memory controller command port. The arbiter takes the slave side.
interface fb_mem_arbiter_if #(
  parameter int ADDR_BITS = 19,
  parameter int DATA_BITS = 24
);
  // Renderer timing
  logic                 fb_hblank;
  logic                 fb_vblank;
  // Scanout fetcher (reads)
  logic                 disp_req;
  logic [ADDR_BITS-1:0] disp_addr;
  logic                 disp_urgent;
  logic                 disp_gnt;
  // Host writer
  logic                 host_req;
  logic [ADDR_BITS-1:0] host_addr;
  logic [DATA_BITS-1:0] host_wdata;
  logic                 host_gnt;
  // Memory controller command
  logic                 mem_valid;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  // Debug
  logic [1:0]           arb_state;
  logic                 host_starved;

  modport slave (
    input  fb_hblank, fb_vblank,
    input  disp_req, disp_addr, disp_urgent,
    output disp_gnt,
    input  host_req, host_addr, host_wdata,
    output host_gnt,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready,
    output arb_state, host_starved
  );

  modport master (
    output fb_hblank, fb_vblank,
    output disp_req, disp_addr, disp_urgent,
    input  disp_gnt,
    output host_req, host_addr, host_wdata,
    input  host_gnt,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready,
    input  arb_state, host_starved
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: one single-port memory shared between the
// scanout fetcher (reads) and the host writer (writes). Display owns the
// memory during active video and late vblank; the host owns it during the
// first lines of vblank. A wait counter forces an occasional host grant when
// display priority would otherwise starve it, unless the fetcher is urgent.
module fb_mem_arbiter #(
  parameter int ADDR_BITS         = 19,
  parameter int DATA_BITS         = 24,
  parameter int HOST_MAX_WAIT     = 16,
  parameter int VBLANK_HOST_LINES = 20
) (
  input  logic          vga_clk,
  input  logic          reset,
  fb_mem_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 2);
  localparam int LINE_W = $clog2(VBLANK_HOST_LINES + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(HOST_MAX_WAIT);
  localparam logic [LINE_W-1:0] LINE_LIMIT = LINE_W'(VBLANK_HOST_LINES);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_VBLANK   = 2'd1,
    ST_PREFETCH = 2'd2
  } arb_state_e;

  arb_state_e           state_q, state_d;
  logic [LINE_W-1:0]    line_cnt_q, line_cnt_d;
  logic [WAIT_W-1:0]    host_wait_q, host_wait_d;
  logic                 host_starved_q, host_starved_d;
  logic                 vblank_q, vblank_d;
  logic                 hblank_q, hblank_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;

  logic slot_free;
  logic host_wins;
  logic disp_gnt;
  logic host_gnt;
  logic vblank_rise;
  logic vblank_fall;
  logic hblank_rise;

  // Pick the winner for this cycle and raise at most one grant.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, starting
    // with a default, so no latch is inferred.
    slot_free = !mem_valid_q || bus.mem_ready;
    host_wins = bus.host_req;
    if (bus.disp_req && bus.host_req) begin
      if (state_q == ST_VBLANK) begin
        host_wins = !bus.disp_urgent;
      end else begin
        host_wins = (host_wait_q == WAIT_MAX) && !bus.disp_urgent;
      end
    end
    host_gnt = !reset && slot_free && bus.host_req && host_wins;
    disp_gnt = !reset && slot_free && bus.disp_req && !host_wins;
  end

  // Load the command register on an accept, empty it when the slot frees up
  // with nothing accepted, otherwise hold it for the memory controller.
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (host_gnt) begin
      mem_valid_d = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = bus.host_addr;
      mem_wdata_d = bus.host_wdata;
    end else if (disp_gnt) begin
      mem_valid_d = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = bus.disp_addr;
    end else if (slot_free) begin
      mem_valid_d = 1'b0;
    end
  end

  // Count how long a requesting host has been refused; a grant (forced or
  // not) or a dropped request restarts the count.
  always_comb begin
    host_wait_d = host_wait_q;
    if (!bus.host_req || host_gnt) begin
      host_wait_d = '0;
    end else if (host_wait_q != WAIT_MAX) begin
      host_wait_d = host_wait_q + WAIT_W'(1);
    end
    host_starved_d = (host_wait_d == WAIT_MAX);
  end

  // Priority phase tracking from blanking edges against the registered copies.
  always_comb begin
    vblank_d    = bus.fb_vblank;
    hblank_d    = bus.fb_hblank;
    vblank_rise = bus.fb_vblank && !vblank_q;
    vblank_fall = !bus.fb_vblank && vblank_q;
    hblank_rise = bus.fb_hblank && !hblank_q;
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (vblank_rise) begin
          state_d    = ST_VBLANK;
          line_cnt_d = '0;
        end
      end
      ST_VBLANK: begin
        if (vblank_fall) begin
          state_d = ST_ACTIVE;
        end else if (line_cnt_q >= LINE_LIMIT) begin
          state_d = ST_PREFETCH;
        end else if (hblank_rise && (line_cnt_q != '1)) begin
          line_cnt_d = line_cnt_q + LINE_W'(1);
        end
      end
      ST_PREFETCH: begin
        if (vblank_fall) begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // State register; reset drops any pending command and returns to ACTIVE.
  always_ff @(posedge vga_clk or posedge reset) begin
    // NOTE: the command data registers are reset too so a reset leaves the
    // memory port at a defined all-zero value, not just an invalid one.
    if (reset) begin
      state_q        <= ST_ACTIVE;
      line_cnt_q     <= '0;
      host_wait_q    <= '0;
      host_starved_q <= 1'b0;
      vblank_q       <= 1'b0;
      hblank_q       <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      line_cnt_q     <= line_cnt_d;
      host_wait_q    <= host_wait_d;
      host_starved_q <= host_starved_d;
      vblank_q       <= vblank_d;
      hblank_q       <= hblank_d;
      mem_valid_q    <= mem_valid_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign bus.disp_gnt     = disp_gnt;
  assign bus.host_gnt     = host_gnt;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.arb_state    = state_q;
  assign bus.host_starved = host_starved_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Testbench for fb_mem_arbiter: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a behavioural model.
module tb_fb_mem_arbiter;
  localparam int AB        = 19;
  localparam int DB        = 24;
  localparam int MAXW      = 16;
  localparam int NLINES    = 20;
  localparam int LINE_LEN  = 10;
  localparam int HB_START  = 7;
  localparam int ACT_LINES = 6;
  localparam int TOT_LINES = 32;

  logic vga_clk = 1'b0;
  logic reset;

  fb_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  fb_mem_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .HOST_MAX_WAIT(MAXW), .VBLANK_HOST_LINES(NLINES)
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit             model_on = 1'b0;
  int             m_mode, m_lines, m_wait;
  bit             m_valid, m_we;
  logic [AB-1:0]  m_addr;
  logic [DB-1:0]  m_wdata;
  bit             m_pv, m_ph;
  bit             exp_dg, exp_hg, m_free, m_host_first;
  bit             disp_acc, host_acc;

  always @(negedge vga_clk) begin
    if (model_on) begin
      if (reset) begin
        m_mode = 0; m_lines = 0; m_wait = 0;
        m_valid = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_pv = 0; m_ph = 0;
        exp_dg = 0; exp_hg = 0;
      end else begin
        m_free = !m_valid || bus.mem_ready;
        if (bus.disp_req && bus.host_req)
          m_host_first = (m_mode == 1) ? !bus.disp_urgent
                                       : (m_wait == MAXW && !bus.disp_urgent);
        else
          m_host_first = bus.host_req;
        exp_hg = m_free && bus.host_req && m_host_first;
        exp_dg = m_free && bus.disp_req && !m_host_first;
      end
      check("disp_gnt",     bus.disp_gnt,     exp_dg);
      check("host_gnt",     bus.host_gnt,     exp_hg);
      check("mem_valid",    bus.mem_valid,    m_valid);
      check("mem_we",       bus.mem_we,       m_we);
      check("mem_addr",     bus.mem_addr,     m_addr);
      check("mem_wdata",    bus.mem_wdata,    m_wdata);
      check("arb_state",    bus.arb_state,    m_mode);
      check("host_starved", bus.host_starved, (m_wait == MAXW));
      disp_acc = bus.disp_req && exp_dg;
      host_acc = bus.host_req && exp_hg;
      if (!reset) begin
        // what the coming clock edge does
        if (exp_hg) begin
          m_valid = 1; m_we = 1; m_addr = bus.host_addr; m_wdata = bus.host_wdata;
        end else if (exp_dg) begin
          m_valid = 1; m_we = 0; m_addr = bus.disp_addr;
        end else if (m_free) begin
          m_valid = 0;
        end
        if (!bus.host_req || exp_hg) m_wait = 0;
        else if (m_wait < MAXW)      m_wait = m_wait + 1;
        case (m_mode)
          0: if (bus.fb_vblank && !m_pv) begin m_mode = 1; m_lines = 0; end
          1: begin
            if (!bus.fb_vblank && m_pv)  m_mode = 0;
            else if (m_lines >= NLINES)  m_mode = 2;
            else if (bus.fb_hblank && !m_ph) m_lines = m_lines + 1;
          end
          default: if (!bus.fb_vblank && m_pv) m_mode = 0;
        endcase
        m_pv = bus.fb_vblank;
        m_ph = bus.fb_hblank;
      end
    end
  end

  // ---------------- renderer timing (shortened lines/frame) ----------------
  bit render_on = 1'b0;
  int rh, rv;

  initial begin
    forever begin
      @(posedge vga_clk);
      #1;
      if (render_on) begin
        if (rh == LINE_LEN - 1) begin
          rh = 0;
          rv = (rv == TOT_LINES - 1) ? 0 : rv + 1;
        end else begin
          rh = rh + 1;
        end
        bus.fb_hblank = (rh >= HB_START);
        bus.fb_vblank = (rv >= ACT_LINES);
      end
    end
  end

  // ---------------- stimulus ----------------
  int cnt, vb_disp, vb_host;
  bit seen_pref;
  int seq[$];
  logic [AB-1:0] addr_a, addr_b;
  logic [DB-1:0] data_a, data_b;

  initial begin
    reset = 1'b1;
    bus.fb_hblank = 0; bus.fb_vblank = 0;
    bus.disp_req = 0; bus.disp_addr = '0; bus.disp_urgent = 0;
    bus.host_req = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.mem_ready = 0;
    model_on = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset in the middle of a stalled command
    bus.mem_ready = 1; bus.host_req = 1;
    bus.host_addr = 19'h0abcd; bus.host_wdata = 24'h112233;
    step();
    bus.mem_ready = 0; bus.host_req = 0;
    @(negedge vga_clk);
    check("midcmd_valid_before", bus.mem_valid, 1);
    step();
    bus.host_req = 1;
    reset = 1'b1;
    #1;
    check("rst_async_valid", bus.mem_valid, 0);
    check("rst_async_host_gnt", bus.host_gnt, 0);
    check("rst_async_disp_gnt", bus.disp_gnt, 0);
    check("rst_async_state", bus.arb_state, 0);
    check("rst_async_addr", bus.mem_addr, 0);
    step();
    step();
    reset = 1'b0; bus.host_req = 0; bus.mem_ready = 1;
    step();

    // Starvation guard in ACTIVE: 16 display grants, then one forced host grant
    bus.disp_addr = 19'h00100; bus.host_addr = 19'h00200; bus.host_wdata = 24'hcafe01;
    bus.disp_req = 1; bus.host_req = 1;
    for (int i = 0; i < 34; i++) begin
      @(negedge vga_clk);
      check("starve_host_gnt", bus.host_gnt, (i % 17 == 16));
      check("starve_disp_gnt", bus.disp_gnt, (i % 17 != 16));
      check("starve_flag", bus.host_starved, (i % 17 == 16));
    end

    // Urgent display shuts the host out completely
    step();
    bus.disp_urgent = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge vga_clk);
      cnt += int'(bus.host_gnt);
    end
    check("urgent_host_gnts", cnt, 0);
    check("urgent_starved", bus.host_starved, 1);
    step();
    bus.disp_urgent = 0; bus.disp_req = 0; bus.host_req = 0;

    // Memory back-pressure with a host write pending
    addr_a = 19'h12345; data_a = 24'habcdef;
    addr_b = 19'h00777; data_b = 24'h135790;
    step();
    bus.host_req = 1; bus.host_addr = addr_a; bus.host_wdata = data_a;
    @(negedge vga_clk);
    check("rdy_first_gnt", bus.host_gnt, 1);
    step();
    bus.mem_ready = 0; bus.host_addr = addr_b; bus.host_wdata = data_b;
    for (int i = 0; i < 5; i++) begin
      @(negedge vga_clk);
      check("rdy_low_host_gnt", bus.host_gnt, 0);
      check("rdy_low_valid", bus.mem_valid, 1);
      check("rdy_low_addr", bus.mem_addr, addr_a);
      check("rdy_low_wdata", bus.mem_wdata, data_a);
    end
    step();
    bus.mem_ready = 1;
    @(negedge vga_clk);
    check("rdy_resume_gnt", bus.host_gnt, 1);
    step();
    bus.host_req = 0;
    @(negedge vga_clk);
    check("rdy_next_valid", bus.mem_valid, 1);
    check("rdy_next_addr", bus.mem_addr, addr_b);
    check("rdy_next_wdata", bus.mem_wdata, data_b);
    check("rdy_next_we", bus.mem_we, 1);

    // Host alone in ACTIVE is granted every cycle
    step();
    bus.host_req = 1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge vga_clk);
      cnt += int'(bus.host_gnt);
    end
    check("host_only_gnts", cnt, 10);
    step();
    bus.host_req = 0;

    // One renderer frame with both requesters held
    step();
    bus.disp_req = 1; bus.host_req = 1;
    @(negedge vga_clk);
    rh = LINE_LEN - 1; rv = TOT_LINES - 1; render_on = 1;
    seq.push_back(int'(bus.arb_state));
    seen_pref = 0; vb_disp = 0; vb_host = 0;
    for (int i = 0; i < 340; i++) begin
      @(negedge vga_clk);
      if (int'(bus.arb_state) != seq[$]) seq.push_back(int'(bus.arb_state));
      if (bus.arb_state == 2'd2 && !seen_pref) begin
        seen_pref = 1;
        check("prefetch_after_lines", (rv - ACT_LINES) + int'(rh >= HB_START), 20);
      end
      if (bus.arb_state == 2'd1) begin
        vb_disp += int'(bus.disp_gnt);
        vb_host += int'(bus.host_gnt);
      end
    end
    check("frame_seq_len", seq.size(), 4);
    for (int k = 0; k < 4; k++)
      check("frame_seq", (seq.size() > k) ? seq[k] : 99, (k == 2) ? 2 : (k == 1) ? 1 : 0);
    check("vblank_disp_gnts", vb_disp, 0);
    check("vblank_host_gnts", vb_host, 198);

    // Randomized traffic under running renderer timing
    for (int i = 0; i < 2500; i++) begin
      step();
      if (!bus.disp_req || disp_acc) begin
        bus.disp_req  = ($urandom_range(0, 9) < 7);
        bus.disp_addr = AB'($urandom);
      end
      if (!bus.host_req || host_acc) begin
        bus.host_req   = ($urandom_range(0, 9) < 5);
        bus.host_addr  = AB'($urandom);
        bus.host_wdata = DB'($urandom);
      end
      bus.disp_urgent = ($urandom_range(0, 9) == 0);
      bus.mem_ready   = ($urandom_range(0, 3) != 0);
      if (i == 1200) reset = 1'b1;
      if (i == 1202) reset = 1'b0;
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
